// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - parametrised sequential ALU with iterative multiply/divide and valid/ready handshake
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_op_valid / o_op_ready     request handshake (ready only while idle)
//   i_codop, i_operando1/2      operation code and operands, latched on accept
//   o_res_valid / i_res_ready   result handshake (valid only while done)
//   o_resultado                 result
//   o_zero, o_carry             result == 0; ADD carry-out / SUB borrow
//   o_div_zero, o_bad_op        DIVU/REMU by zero; codop outside 0..8
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [3:0]       i_codop,
    input  logic [WIDTH-1:0] i_operando1,
    input  logic [WIDTH-1:0] i_operando2,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_resultado,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_div_zero,
    output logic             o_bad_op
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_codop;
    logic [WIDTH-1:0] r_a;      // MUL: multiplicand, shifted left each step
    logic [WIDTH-1:0] r_b;      // MUL: multiplier, shifted right; DIV: divisor
    logic [WIDTH-1:0] r_acc;    // MUL: partial product; DIV: partial remainder
    logic [WIDTH-1:0] r_q;      // DIV: dividend bits shifted out, quotient shifted in
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_carry;
    logic             r_div_zero;
    logic             r_bad_op;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_imm_res;
    logic             w_imm_carry;
    logic             w_imm_dz;
    logic             w_imm_bad;
    logic             w_iter;

    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_dif;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_iter_res;

    assign w_accept = i_op_valid && (r_state == S_IDLE);
    assign w_sum    = {1'b0, i_operando1} + {1'b0, i_operando2};
    assign w_dif    = {1'b0, i_operando1} - {1'b0, i_operando2};

    // Result of everything that completes on the accept edge; w_iter marks
    // the ops that instead need WIDTH iteration steps.
    always_comb begin
        w_imm_res   = '0;
        w_imm_carry = 1'b0;
        w_imm_dz    = 1'b0;
        w_imm_bad   = 1'b0;
        w_iter      = 1'b0;
        case (i_codop)
            4'd0: begin
                w_imm_res   = w_sum[WIDTH-1:0];
                w_imm_carry = w_sum[WIDTH];
            end
            4'd1: begin
                w_imm_res   = w_dif[WIDTH-1:0];
                w_imm_carry = w_dif[WIDTH];
            end
            4'd2: w_imm_res = {{(WIDTH-1){1'b0}}, (i_operando1 > i_operando2)};
            4'd3: w_imm_res = i_operando1 & i_operando2;
            4'd4: w_imm_res = i_operando1 | i_operando2;
            4'd5: w_imm_res = i_operando1 ^ i_operando2;
            4'd6: w_iter = 1'b1;
            4'd7, 4'd8: begin
                if (i_operando2 == '0) begin
                    w_imm_dz  = 1'b1;
                    w_imm_res = (i_codop == 4'd7) ? '1 : i_operando1;
                end else begin
                    w_iter = 1'b1;
                end
            end
            default: w_imm_bad = 1'b1;
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIVU/REMU) step. Bit WIDTH of
    // w_rem_dif is the borrow: set when the shifted remainder is below the divisor.
    assign w_mul_acc  = r_acc + (r_b[0] ? r_a : '0);
    assign w_rem_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_rem_dif  = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = ~w_rem_dif[WIDTH];
    assign w_rem_nx   = w_q_bit ? w_rem_dif[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_q_nx     = {r_q[WIDTH-2:0], w_q_bit};
    assign w_iter_res = (r_codop == 4'd6) ? w_mul_acc :
                        (r_codop == 4'd7) ? w_q_nx    : w_rem_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_iter ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: if (i_res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_codop    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
            r_bad_op   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_codop <= i_codop;
                        r_a     <= i_operando1;
                        r_b     <= i_operando2;
                        r_acc   <= '0;
                        r_q     <= i_operando1;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        if (!w_iter) begin
                            r_res      <= w_imm_res;
                            r_zero     <= (w_imm_res == '0);
                            r_carry    <= w_imm_carry;
                            r_div_zero <= w_imm_dz;
                            r_bad_op   <= w_imm_bad;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_codop == 4'd6) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_acc <= w_rem_nx;
                        r_q   <= w_q_nx;
                    end
                    if (r_cnt == '0) begin
                        r_res      <= w_iter_res;
                        r_zero     <= (w_iter_res == '0);
                        r_carry    <= 1'b0;
                        r_div_zero <= 1'b0;
                        r_bad_op   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // Flags are only meaningful while the result is presented.
                    if (i_res_ready) begin
                        r_zero     <= 1'b0;
                        r_carry    <= 1'b0;
                        r_div_zero <= 1'b0;
                        r_bad_op   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_op_ready  = (r_state == S_IDLE);
    assign o_res_valid = (r_state == S_DONE);
    assign o_resultado = r_res;
    assign o_zero      = r_zero;
    assign o_carry     = r_carry;
    assign o_div_zero  = r_div_zero;
    assign o_bad_op    = r_bad_op;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=16 and WIDTH=8
module tb_alu_seq;
    typedef struct {
        int          sel;
        logic [15:0] res;
        logic        carry;
        logic        dz;
        logic        bad;
        logic        zero;
        int          lat;
        int          acc_neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  op_valid;
    logic [1:0]  res_ready;
    logic [3:0]  codop [2];
    logic [15:0] opa [2];
    logic [15:0] opb [2];
    logic [1:0]  op_ready, res_valid, zero, carry, dz, bad;
    logic [15:0] res16;
    logic [7:0]  res8;

    exp_t sbq[$];
    exp_t cur [2];
    logic [1:0] seen;
    logic [1:0] cur_ok;
    int negcount = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) u_alu16 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_op_valid(op_valid[0]), .o_op_ready(op_ready[0]),
        .i_codop(codop[0]), .i_operando1(opa[0]), .i_operando2(opb[0]),
        .o_res_valid(res_valid[0]), .i_res_ready(res_ready[0]),
        .o_resultado(res16), .o_zero(zero[0]), .o_carry(carry[0]),
        .o_div_zero(dz[0]), .o_bad_op(bad[0])
    );

    alu_seq #(.WIDTH(8)) u_alu8 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_op_valid(op_valid[1]), .o_op_ready(op_ready[1]),
        .i_codop(codop[1]), .i_operando1(opa[1][7:0]), .i_operando2(opb[1][7:0]),
        .o_res_valid(res_valid[1]), .i_res_ready(res_ready[1]),
        .o_resultado(res8), .o_zero(zero[1]), .o_carry(carry[1]),
        .o_div_zero(dz[1]), .o_bad_op(bad[1])
    );

    function automatic logic [15:0] rd_res(int i);
        return (i == 0) ? res16 : {8'h00, res8};
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: plain unsigned arithmetic on w-bit values.
    function automatic exp_t model(int sel, int w, logic [3:0] op, logic [15:0] a_in, logic [15:0] b_in);
        exp_t   e;
        longint m = (longint'(1) << w) - 1;
        longint a = longint'(a_in) & m;
        longint b = longint'(b_in) & m;
        longint r = 0;
        e.sel = sel; e.carry = 0; e.dz = 0; e.bad = 0; e.lat = 1; e.acc_neg = 0;
        case (op)
            4'd0: begin r = a + b; e.carry = (r > m); r = r & m; end
            4'd1: begin e.carry = (a < b); r = (a - b) & m; end
            4'd2: r = (a > b) ? 1 : 0;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = (a * b) & m; e.lat = w + 1; end
            4'd7: if (b == 0) begin r = m; e.dz = 1; end else begin r = a / b; e.lat = w + 1; end
            4'd8: if (b == 0) begin r = a; e.dz = 1; end else begin r = a % b; e.lat = w + 1; end
            default: begin r = 0; e.bad = 1; end
        endcase
        e.res  = 16'(r);
        e.zero = (r == 0);
        return e;
    endfunction

    // Monitor: pops the scoreboard when a result first appears, then checks it stays stable.
    always @(negedge clk) begin
        negcount++;
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                if (res_valid[i]) begin
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        if (sbq.size() == 0 || sbq[0].sel != i) begin
                            cur_ok[i] = 1'b0;
                            chk($sformatf("unexpected_result[%0d]", i), 1, 0);
                        end else begin
                            cur[i] = sbq.pop_front();
                            cur_ok[i] = 1'b1;
                            chk($sformatf("latency[%0d]", i), negcount - cur[i].acc_neg, cur[i].lat);
                        end
                    end
                    if (cur_ok[i]) begin
                        chk($sformatf("resultado[%0d]", i), rd_res(i), cur[i].res);
                        chk($sformatf("zero[%0d]", i), zero[i], cur[i].zero);
                        chk($sformatf("carry[%0d]", i), carry[i], cur[i].carry);
                        chk($sformatf("div_zero[%0d]", i), dz[i], cur[i].dz);
                        chk($sformatf("bad_op[%0d]", i), bad[i], cur[i].bad);
                    end
                    chk($sformatf("ready_in_done[%0d]", i), op_ready[i], 0);
                end else begin
                    seen[i] = 1'b0;
                    if (sbq.size() > 0 && sbq[0].sel == i)
                        chk($sformatf("ready_in_busy[%0d]", i), op_ready[i], 0);
                end
            end
        end
    end

    task automatic run_op(int sel, logic [3:0] op, logic [15:0] a, logic [15:0] b, int hold, bit junk);
        exp_t e;
        int   n;
        @(negedge clk);
        codop[sel] = op; opa[sel] = a; opb[sel] = b; op_valid[sel] = 1'b1;
        n = 0;
        while (!op_ready[sel] && n < 50) begin @(negedge clk); n++; end
        if (!op_ready[sel]) begin
            chk("accept_timeout", 1, 0);
            op_valid[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        op_valid[sel] = 1'b0;
        codop[sel] = 4'($urandom); opa[sel] = 16'($urandom); opb[sel] = 16'($urandom);
        e = model(sel, (sel == 0) ? 16 : 8, op, a, b);
        e.acc_neg = negcount;
        sbq.push_back(e);
        @(negedge clk);
        n = 1;
        while (!res_valid[sel] && n < 60) begin @(negedge clk); n++; end
        if (!res_valid[sel]) begin
            chk("result_timeout", 1, 0);
            sbq.delete();
            return;
        end
        if (junk) op_valid[sel] = 1'b1;
        repeat (hold) @(negedge clk);
        op_valid[sel] = 1'b0;
        res_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[sel] = 1'b0;
    endtask

    initial begin
        op_valid = '0; res_ready = '0; seen = '0; cur_ok = '0;
        for (int i = 0; i < 2; i++) begin codop[i] = '0; opa[i] = '0; opb[i] = '0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_op_ready[%0d]", i), op_ready[i], 1);
            chk($sformatf("rst_res_valid[%0d]", i), res_valid[i], 0);
            chk($sformatf("rst_resultado[%0d]", i), rd_res(i), 0);
            chk($sformatf("rst_flags[%0d]", i), {zero[i], carry[i], dz[i], bad[i]}, 0);
        end
        rst_n = 1'b1;

        // WIDTH=16 directed
        run_op(0, 4'd0, 16'hFFFF, 16'h0001, 0, 0);
        run_op(0, 4'd1, 16'd5, 16'd7, 1, 0);
        run_op(0, 4'd2, 16'd7, 16'd5, 0, 0);
        run_op(0, 4'd2, 16'd5, 16'd5, 0, 0);
        run_op(0, 4'd6, 16'h0123, 16'h0045, 0, 0);
        run_op(0, 4'd7, 16'd1000, 16'd7, 0, 0);
        run_op(0, 4'd8, 16'd1000, 16'd7, 0, 0);
        run_op(0, 4'd7, 16'd9, 16'd0, 0, 0);
        run_op(0, 4'd8, 16'd9, 16'd0, 0, 0);
        run_op(0, 4'd6, 16'h1234, 16'h5678, 10, 1);
        run_op(0, 4'd12, 16'h1234, 16'h5678, 10, 1);

        // WIDTH=8 directed
        run_op(1, 4'd0, 16'h00FF, 16'h0001, 0, 0);
        run_op(1, 4'd6, 16'h0010, 16'h0010, 0, 0);
        run_op(1, 4'd7, 16'd100, 16'd7, 0, 0);
        run_op(1, 4'd8, 16'd100, 16'd7, 0, 0);
        run_op(1, 4'd7, 16'd9, 16'd0, 0, 0);

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        codop[0] = 4'd6; opa[0] = 16'h0123; opb[0] = 16'h0045; op_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        op_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", res_valid[0], 0);
        chk("abort_op_ready", op_ready[0], 1);
        chk("abort_resultado", rd_res(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 4'd0, 16'd2, 16'd3, 0, 0);

        // Randomized traffic on both widths
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 40; k++) begin
                logic [3:0]  op;
                logic [15:0] a, b;
                op = 4'($urandom_range(0, 15));
                a  = 16'($urandom);
                b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
                if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
                run_op(s, op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
